// File: rtl/inv_shift_row_stream.sv
// Byte-serial AES InvShiftRows stage with ping-pong 16-byte banks.
// Optional INV_SHIFT_ROW_FWD_EN adds a per-block fwd input selecting forward ShiftRows.
module inv_shift_row_stream (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
`ifdef INV_SHIFT_ROW_FWD_EN
  input  logic       fwd,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned BLK_LEN = 16;
  localparam int unsigned CNT_W   = 4;

  logic [BYTE_W-1:0] bank_q [2][BLK_LEN];
  logic [BYTE_W-1:0] bank_d [2][BLK_LEN];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
`ifdef INV_SHIFT_ROW_FWD_EN
  logic [1:0]        mode_q, mode_d;
`endif

  logic       in_fire;
  logic       out_fire;
  logic [1:0] row;
  logic [1:0] col;
  logic [1:0] src_col;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_last  = out_valid & (rd_cnt_q == CNT_W'(BLK_LEN - 1));

  // Fill/drain bookkeeping; set and clear of full never hit the same bank in one cycle.
  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
`ifdef INV_SHIFT_ROW_FWD_EN
    mode_d    = mode_q;
    if (in_fire && (wr_cnt_q == '0)) begin
      mode_d[wr_bank_q] = fwd;
    end
`endif
    if (in_fire) begin
      bank_d[wr_bank_q][wr_cnt_q] = in_data;
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if (wr_cnt_q == CNT_W'(BLK_LEN - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (out_fire) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
      if (rd_cnt_q == CNT_W'(BLK_LEN - 1)) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  // Output beat k = 4*col + row reads the byte whose column is rotated by the row index.
  always_comb begin
    row = rd_cnt_q[1:0];
    col = rd_cnt_q[3:2];
`ifdef INV_SHIFT_ROW_FWD_EN
    src_col = mode_q[rd_bank_q] ? (col + row) : (col - row);
`else
    src_col = col - row;
`endif
    out_data = out_valid ? bank_q[rd_bank_q][{src_col, row}] : '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bank_q    <= '{default: '0};
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
`ifdef INV_SHIFT_ROW_FWD_EN
      mode_q    <= '0;
`endif
    end else begin
      bank_q    <= bank_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
`ifdef INV_SHIFT_ROW_FWD_EN
      mode_q    <= mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_inv_shift_row_stream.sv
// Self-checking bench for inv_shift_row_stream: directed and randomized
// traffic scored against a row-rotation model of (Inv)ShiftRows.
module tb_inv_shift_row_stream;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       fwd;

  inv_shift_row_stream dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
`ifdef INV_SHIFT_ROW_FWD_EN
    .fwd       (fwd),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  logic [7:0] exp_q [$];
  logic [7:0] blk [16];
  int         in_pos  = 0;
  int         out_pos = 0;
  bit         blk_fwd = 1'b0;
  int         cyc     = 0;
  int         tot_in  = 0;
  int         tot_out = 0;
  int         first_fire = -1;
  int         last_fire  = -1;
  int         first_valid = -1;
  int         last_accept = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // AES state is column-major; ShiftRows rotates row r left by r, InvShiftRows right by r.
  task automatic push_block(input bit fw);
    logic [7:0] st [4][4];
    logic [7:0] sh [4][4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = blk[4*c + r];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sh[r][c] = fw ? st[r][(c + r) % 4] : st[r][(c + 4 - r) % 4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        exp_q.push_back(sh[r][c]);
  endtask

  // One clock: drive at the falling edge, check outputs, then advance the model.
  task automatic step(input logic iv, input logic [7:0] d, input logic orr, input logic f);
    int nfull;
    @(negedge sys_clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    fwd       = f;
    #1;
    nfull = (exp_q.size() + 15) / 16;
    chk("in_ready", 32'(in_ready), 32'(nfull < 2));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(exp_q[0]));
      chk("out_last", 32'(out_last), 32'(out_pos == 15));
    end else begin
      chk("out_last_idle", 32'(out_last), 32'(0));
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && out_ready) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      out_pos = (out_pos + 1) % 16;
      tot_out++;
      if (first_fire < 0) first_fire = cyc;
      last_fire = cyc;
    end
    if (in_valid && in_ready) begin
`ifdef INV_SHIFT_ROW_FWD_EN
      if (in_pos == 0) blk_fwd = f;
`else
      blk_fwd = 1'b0;
`endif
      blk[in_pos] = d;
      in_pos++;
      tot_in++;
      last_accept = cyc;
      if (in_pos == 16) begin
        push_block(blk_fwd);
        in_pos = 0;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    exp_q.delete();
    in_pos  = 0;
    out_pos = 0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic send_seq(input int n, input logic [7:0] base, input logic orr);
    for (int i = 0; i < n; i++) step(1'b1, 8'(base + 8'(i)), orr, 1'b0);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    fwd       = 1'b0;
    #12;
    do_reset();

    // Directed block 0x00..0x0F; first valid one cycle after the last accept.
    first_valid = -1;
    send_seq(16, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("latency", 32'(first_valid - last_accept), 32'(1));
    drain();

`ifdef INV_SHIFT_ROW_FWD_EN
    // Forward block then feeding its output back through inverse restores the input.
    begin
      logic [7:0] got [$];
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, i == 0);
      for (int i = 0; i < 40 && got.size() < 16; i++) begin
        if (out_valid) got.push_back(out_data);
        step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      for (int i = 0; i < 16; i++) step(1'b1, got[i], 1'b1, 1'b0);
      drain();
      chk("fwd_got16", 32'(got.size()), 32'(16));
    end
`endif

    // Four back-to-back blocks with both sides always ready.
    first_fire = -1;
    for (int i = 0; i < 64; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    drain();
    chk("b2b_span", 32'(last_fire - first_fire), 32'(63));

    // Stall output while two blocks load; input must back-pressure.
    send_seq(16, 8'h00, 1'b0);
    send_seq(16, 8'h40, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h99, 1'b0, 1'b0);
    chk("stall_in_ready", 32'(in_ready), 32'(0));
    chk("stall_data", 32'(out_data), 32'(0));
    for (int i = 0; i < 18; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    drain();

    // Randomly throttled traffic, 100 blocks.
    begin
      int base_in = tot_in;
      int base_out = tot_out;
      int n = 0;
      while (((tot_in - base_in) < 1600 || exp_q.size() > 0) && n < 20000) begin
        step(((tot_in - base_in) < 1600) && ($urandom_range(3) != 0),
             8'($urandom), $urandom_range(2) != 0, 1'($urandom));
        n++;
      end
      chk("rand_in", 32'(tot_in - base_in), 32'(1600));
      chk("rand_out", 32'(tot_out - base_out), 32'(1600));
    end

    // Reset mid-fill and mid-drain; following block must be clean.
    send_seq(7, 8'hA0, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    send_seq(16, 8'h10, 1'b1);
    drain();
    send_seq(16, 8'h20, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    send_seq(16, 8'h30, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
